// File: rtl/cv32e40s_fencei_sequencer.sv
// Sequences the fence.i instruction-side flush: drain the LSU, then run req/ack on fencei_flush.
// Optional ack-timeout watchdog is enabled by defining CV32E40S_FENCEI_TIMEOUT_EN.
module cv32e40s_fencei_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        kill_i,
  input  logic        lsu_busy_i,
  input  logic        fencei_flush_ack_i,
  output logic        fencei_flush_req_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        killed_o,
  output logic [31:0] branch_addr_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    REQ,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        killed_q, killed_d;
  logic [31:0] branch_addr_q, branch_addr_d;

  // Outputs are derived from the next state so they appear registered with no input-to-req path.
  always_comb begin
    state_d       = state_q;
    branch_addr_d = branch_addr_q;
    killed_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d       = DRAIN;
          branch_addr_d = pc_i + 32'd4;
        end
      end
      DRAIN: begin
        if (kill_i) begin
          state_d  = IDLE;
          killed_d = 1'b1;
        end else if (!lsu_busy_i) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (fencei_flush_ack_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      killed_q      <= 1'b0;
      branch_addr_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      killed_q      <= killed_d;
      branch_addr_q <= branch_addr_d;
    end
  end

  assign fencei_flush_req_o = req_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign killed_o           = killed_q;
  assign branch_addr_o      = branch_addr_q;

`ifdef CV32E40S_FENCEI_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = 16'(ACK_TIMEOUT);

  logic [15:0] ack_wait_q, ack_wait_d;
  logic        timeout_q, timeout_d;

  // Counts unacknowledged REQ cycles and saturates, so the pulse fires only once per request.
  always_comb begin
    ack_wait_d = 16'h0;
    timeout_d  = 1'b0;
    if ((state_q == REQ) && !fencei_flush_ack_i) begin
      if (ack_wait_q != TimeoutLimit) begin
        ack_wait_d = ack_wait_q + 16'd1;
      end else begin
        ack_wait_d = ack_wait_q;
      end
      timeout_d = (ack_wait_q == (TimeoutLimit - 16'd1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_wait_q <= 16'h0;
      timeout_q  <= 1'b0;
    end else begin
      ack_wait_q <= ack_wait_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40s_fencei_sequencer.sv
// Randomized and directed bench for cv32e40s_fencei_sequencer against a cycle-level reference model.
module tb_cv32e40s_fencei_sequencer;

  localparam int unsigned AckTimeout = 4;
`ifdef CV32E40S_FENCEI_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] pc_i;
  logic        kill_i;
  logic        lsu_busy_i;
  logic        fencei_flush_ack_i;
  logic        fencei_flush_req_o;
  logic        busy_o;
  logic        done_o;
  logic        killed_o;
  logic [31:0] branch_addr_o;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;

  cv32e40s_fencei_sequencer #(.ACK_TIMEOUT(AckTimeout)) dut (
    .clk                (clk),
    .rst                (rst),
    .start_i            (start_i),
    .pc_i               (pc_i),
    .kill_i             (kill_i),
    .lsu_busy_i         (lsu_busy_i),
    .fencei_flush_ack_i (fencei_flush_ack_i),
    .fencei_flush_req_o (fencei_flush_req_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .killed_o           (killed_o),
    .branch_addr_o      (branch_addr_o),
    .timeout_o          (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: phase of the flush sequence plus the number of unacknowledged request cycles.
  string       m_phase = "idle";
  int          m_unacked = 0;
  logic [31:0] m_addr = 32'h0;
  bit          m_killed = 1'b0;
  bit          m_timeout = 1'b0;
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    m_killed  = 1'b0;
    m_timeout = 1'b0;
    if (rst) begin
      m_phase   = "idle";
      m_unacked = 0;
      m_addr    = 32'h0;
    end else if (m_phase == "idle") begin
      if (start_i) begin
        m_phase = "drain";
        m_addr  = pc_i + 32'd4;
      end
    end else if (m_phase == "drain") begin
      if (kill_i) begin
        m_phase  = "idle";
        m_killed = 1'b1;
      end else if (!lsu_busy_i) begin
        m_phase   = "req";
        m_unacked = 0;
      end
    end else if (m_phase == "req") begin
      if (fencei_flush_ack_i) begin
        m_phase = "done";
      end else begin
        m_unacked++;
        m_timeout = TimeoutEn && (m_unacked == AckTimeout);
      end
    end else begin
      m_phase = "idle";
    end
    model_live = 1'b1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("model_req", fencei_flush_req_o, 32'(m_phase == "req"));
      checkOutput("model_busy", busy_o, 32'(m_phase != "idle"));
      checkOutput("model_done", done_o, 32'(m_phase == "done"));
      checkOutput("model_killed", killed_o, 32'(m_killed));
      checkOutput("model_branch_addr", branch_addr_o, m_addr);
      checkOutput("model_timeout", timeout_o, 32'(m_timeout));
      checkOutput("done_killed_exclusive", done_o & killed_o, 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] pc, input logic k, input logic lsu, input logic ack);
    start_i            = s;
    pc_i               = pc;
    kill_i             = k;
    lsu_busy_i         = lsu;
    fencei_flush_ack_i = ack;
  endtask

  initial begin
    int first_to;
    int to_pulses;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_req", fencei_flush_req_o, 32'h0);
    checkOutput("reset_busy", busy_o, 32'h0);
    checkOutput("reset_branch", branch_addr_o, 32'h0);
    rst = 1'b0;
    tick();

    // Basic flush with immediate ack
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("basic_c1_busy", busy_o, 32'h1);
    checkOutput("basic_c1_req", fencei_flush_req_o, 32'h0);
    checkOutput("basic_branch", branch_addr_o, 32'h0000_1004);
    tick();
    checkOutput("basic_c2_req", fencei_flush_req_o, 32'h1);
    fencei_flush_ack_i = 1'b1;
    tick();
    fencei_flush_ack_i = 1'b0;
    checkOutput("basic_c3_done", done_o, 32'h1);
    checkOutput("basic_c3_req", fencei_flush_req_o, 32'h0);
    tick();
    checkOutput("basic_c4_busy", busy_o, 32'h0);
    checkOutput("basic_c4_done", done_o, 32'h0);

    // Drain wait
    applyStimulus(1'b1, 32'h0000_2000, 1'b0, 1'b1, 1'b0);
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("drain_req_low", fencei_flush_req_o, 32'h0);
      tick();
    end
    lsu_busy_i = 1'b0;
    tick();
    checkOutput("drain_req_rise", fencei_flush_req_o, 32'h1);
    fencei_flush_ack_i = 1'b1;
    tick();
    fencei_flush_ack_i = 1'b0;
    checkOutput("drain_done", done_o, 32'h1);
    tick();

    // Kill in DRAIN
    applyStimulus(1'b1, 32'h0000_3000, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    kill_i = 1'b0;
    checkOutput("kill_drain_killed", killed_o, 32'h1);
    checkOutput("kill_drain_busy", busy_o, 32'h0);
    checkOutput("kill_drain_req", fencei_flush_req_o, 32'h0);
    tick();
    checkOutput("kill_drain_pulse_end", killed_o, 32'h0);

    // Kill in REQ is ignored
    applyStimulus(1'b1, 32'h0000_4000, 1'b0, 1'b0, 1'b0);
    tick();
    start_i = 1'b0;
    tick();
    kill_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("kill_req_held", fencei_flush_req_o, 32'h1);
    end
    fencei_flush_ack_i = 1'b1;
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("kill_req_done", done_o, 32'h1);
    checkOutput("kill_req_not_killed", killed_o, 32'h0);
    tick();

    // Wrap, ignored start while busy, stray ack in IDLE
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("wrap_branch", branch_addr_o, 32'h0);
    pc_i = 32'h0000_1234;
    tick();
    checkOutput("ignore_start_branch", branch_addr_o, 32'h0);
    checkOutput("ignore_start_busy", busy_o, 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("stray_ack_busy", busy_o, 32'h0);
    checkOutput("stray_ack_done", done_o, 32'h0);
    checkOutput("branch_holds", branch_addr_o, 32'h0);
    fencei_flush_ack_i = 1'b0;

    // Reset while req is high
    applyStimulus(1'b1, 32'h0000_5000, 1'b0, 1'b0, 1'b0);
    tick();
    start_i = 1'b0;
    tick();
    checkOutput("rst_req_pre", fencei_flush_req_o, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_req_req", fencei_flush_req_o, 32'h0);
    checkOutput("rst_req_busy", busy_o, 32'h0);
    checkOutput("rst_req_branch", branch_addr_o, 32'h0);
    applyStimulus(1'b1, 32'h0000_6000, 1'b0, 1'b0, 1'b0);
    tick();
    start_i = 1'b0;
    checkOutput("rst_rerun_branch", branch_addr_o, 32'h0000_6004);
    tick();
    fencei_flush_ack_i = 1'b1;
    tick();
    fencei_flush_ack_i = 1'b0;
    checkOutput("rst_rerun_done", done_o, 32'h1);
    tick();

    // Ack timeout: ack withheld until the 10th REQ cycle
    applyStimulus(1'b1, 32'h0000_7000, 1'b0, 1'b0, 1'b0);
    tick();
    start_i = 1'b0;
    tick();
    first_to  = 0;
    to_pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      if (timeout_o) begin
        to_pulses++;
        if (first_to == 0) first_to = c;
      end
      checkOutput("timeout_req_held", fencei_flush_req_o, 32'h1);
      if (c == 10) fencei_flush_ack_i = 1'b1;
      tick();
    end
    fencei_flush_ack_i = 1'b0;
    checkOutput("timeout_done", done_o, 32'h1);
    if (TimeoutEn) begin
      checkOutput("timeout_first_cycle", 32'(first_to), 32'd5);
      checkOutput("timeout_pulse_count", 32'(to_pulses), 32'd1);
    end else begin
      checkOutput("timeout_pulse_count", 32'(to_pulses), 32'd0);
    end
    tick();

    // Random traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      applyStimulus($urandom_range(0, 3) == 0,
                    ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) == 0);
      tick();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
